// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: unsigned 16x16 -> 32 multiplier built around one shared
// 8x8 Wallace-tree multiplier. The four operand-half products are computed
// over four MUL cycles and accumulated, shifted, into a 32-bit register.
// Optional build macro MUL16_ZERO_SKIP_EN: a zero operand at accept jumps
// straight to DONE with a cleared accumulator (latency 1 instead of 4).

// Combinational 8x8 unsigned multiplier: partial products reduced by
// carry-save (3:2) layers down to two rows, then one carry-propagate add.
module wallace_8bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] pp [8];
    logic [15:0] s  [6];
    logic [15:0] c  [6];

    // Each bit of b gates a copy of a, placed at its binary weight.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp
        assign pp[gi] = {8'b0, a & {8{b[gi]}}} << gi;
    end

    function automatic logic [15:0] csa_sum(input logic [15:0] x, y, z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [15:0] csa_carry(input logic [15:0] x, y, z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // Layer 1: 8 rows -> 6 rows
    assign s[0] = csa_sum  (pp[0], pp[1], pp[2]);
    assign c[0] = csa_carry(pp[0], pp[1], pp[2]);
    assign s[1] = csa_sum  (pp[3], pp[4], pp[5]);
    assign c[1] = csa_carry(pp[3], pp[4], pp[5]);
    // Layer 2: 6 rows -> 4 rows
    assign s[2] = csa_sum  (s[0], c[0], s[1]);
    assign c[2] = csa_carry(s[0], c[0], s[1]);
    assign s[3] = csa_sum  (c[1], pp[6], pp[7]);
    assign c[3] = csa_carry(c[1], pp[6], pp[7]);
    // Layer 3: 4 rows -> 3 rows
    assign s[4] = csa_sum  (s[2], c[2], s[3]);
    assign c[4] = csa_carry(s[2], c[2], s[3]);
    // Layer 4: 3 rows -> 2 rows
    assign s[5] = csa_sum  (s[4], c[4], c[3]);
    assign c[5] = csa_carry(s[4], c[4], c[3]);

    // The product fits in 16 bits, so the modulo-2^16 final add is exact.
    assign p = s[5] + c[5];
endmodule

module mul16_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q,  step_d;
    logic [15:0] a_q,     a_d;
    logic [15:0] b_q,     b_d;
    logic [31:0] acc_q,   acc_d;

    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic [4:0]  shamt;
    logic [31:0] partial;
    logic        accept;

    // step[1] selects the high half of a, step[0] the high half of b.
    assign mul_a = step_q[1] ? a_q[15:8] : a_q[7:0];
    assign mul_b = step_q[0] ? b_q[15:8] : b_q[7:0];

    wallace_8bit u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Weight of the current partial product: lo*lo=0, cross terms=8, hi*hi=16.
    always_comb begin
        shamt = 5'd8;
        case (step_q)
            2'd0:    shamt = 5'd0;
            2'd3:    shamt = 5'd16;
            default: shamt = 5'd8;
        endcase
    end

    assign partial    = {16'b0, mul_p} << shamt;
    assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept     = in_valid & in_ready;
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_result = acc_q;

    // Next-state logic: accept/restart, step through the four products, hold DONE.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            S_MUL: begin
                acc_d  = acc_q + partial;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        // A new operand pair may be taken in IDLE or in the releasing DONE cycle.
        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            acc_d   = 32'd0;
            step_d  = 2'd0;
            state_d = S_MUL;
`ifdef MUL16_ZERO_SKIP_EN
            if ((in_a == 16'd0) || (in_b == 16'd0)) begin
                state_d = S_DONE;
            end
`endif
        end
    end

    // State and datapath registers; reset discards any in-flight product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            acc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Testbench for mul16_seq_ctrl: directed cases plus randomized operands with
// random output backpressure. Accepted operand pairs push an expected product
// and latency into a scoreboard; a monitor pops and compares on each result.
module tb_mul16_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;

    logic        ready_force = 1'b1;
    logic        bp_rand = 1'b0;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          hs_cyc = -1;
    bit          seen = 1'b0;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    mul16_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain integer product; latency from the operand rule.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        e.res     = 32'(a) * 32'(b);
        e.acc_cyc = acc;
        e.lat     = 4;
`ifdef MUL16_ZERO_SKIP_EN
        if (a == 16'd0 || b == 16'd0) e.lat = 1;
`endif
        return e;
    endfunction

    // Present one operand pair until accepted; returns the accept edge number.
    task automatic send(input logic [15:0] a, input logic [15:0] b, output int acc);
        int n = 0;
        acc = -1;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) break;
        end
        if (in_ready) begin
            acc = cyc + 1;
            sb.push_back(model(a, b, acc));
        end else begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("send a=%h b=%h accepted at cycle %0d", a, b, acc);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        #1;
    endtask

    function automatic logic [15:0] pick();
        int r = $urandom_range(0, 9);
        logic [15:0] v = 16'($urandom);
        if (r == 0) v = 16'h0000;
        else if (r == 1) v = 16'hFFFF;
        return v;
    endfunction

    // Monitor: compare every presented result, latency on first sight, pop on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
                    seen = 1'b1;
                end
                check("result", out_result, sb[0].res);
                check("busy_done", 32'(busy), 32'd1);
                if (!out_ready) check("in_ready_bp", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    $display("result %h at cycle %0d", out_result, cyc + 1);
                    hs_cyc = cyc + 1;
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int acc1;
        int acc2;
        logic [15:0] ra;
        logic [15:0] rb;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-scale product.
        send(16'hFFFF, 16'hFFFF, acc1);
        wait_drain();

        // Back-to-back: second accept lands in the first one's DONE cycle.
        send(16'h1234, 16'h5678, acc1);
        send(16'h00FF, 16'hFF00, acc2);
        check("b2b_spacing", 32'(acc2 - acc1), 32'd5);
        wait_drain();

        // Backpressure: result held while out_ready is low, then overlapped accept.
        ready_force = 1'b0;
        send(16'h0002, 16'h0003, acc1);
        repeat (14) @(posedge clk);
        #1;
        check("bp_held_valid", 32'(out_valid), 32'd1);
        check("bp_held_result", out_result, 32'h00000006);
        ready_force = 1'b1;
        send(16'h0007, 16'h0009, acc2);
        check("bp_overlap_accept", 32'(acc2), 32'(hs_cyc));
        wait_drain();

        // Zero operand.
        send(16'h0000, 16'hABCD, acc1);
        wait_drain();

        // Reset during MUL step 2: product discarded.
        send(16'h8000, 16'h8000, acc1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_result", out_result, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0003, 16'h0005, acc1);
        wait_drain();

        // Randomized operands, gaps and backpressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = pick();
            rb = pick();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(ra, rb, acc1);
        end
        bp_rand = 1'b0;
        wait_drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
